// File: rtl/gpr_file.sv
// Register file for a small 8-bit core. It holds the special registers INDF, TMR0, PCL,
// STATUS, FSR and PORTA/B/C, plus general-purpose bytes, behind one latched address.
// Config macro GPR_FILE_PORTC_EN: when defined, address 7 is the PORTC latch. When it is
// undefined, address 7 is one more GPR and portCOut is tied low.
module gpr_file (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] writeCommand,
  input  logic [7:0] gprWriteDataIn,
  input  logic [7:0] statusWriteDataIn,
  input  logic       tmr0Inc,
  input  logic [7:0] pclIn,
  output logic [7:0] readDataOut,
  output logic [7:0] statusOut,
  output logic       pclWriteEn,
  output logic [7:0] pclWriteData,
  output logic [3:0] portAOut,
  output logic [7:0] portBOut,
  output logic [7:0] portCOut
);

  localparam logic [4:0] AddrIndf   = 5'd0;
  localparam logic [4:0] AddrTmr0   = 5'd1;
  localparam logic [4:0] AddrPcl    = 5'd2;
  localparam logic [4:0] AddrStatus = 5'd3;
  localparam logic [4:0] AddrFsr    = 5'd4;
  localparam logic [4:0] AddrPortA  = 5'd5;
  localparam logic [4:0] AddrPortB  = 5'd6;
  localparam logic [4:0] AddrPortC  = 5'd7;

`ifdef GPR_FILE_PORTC_EN
  localparam logic [4:0] GprBase = 5'd8;
`else
  localparam logic [4:0] GprBase = 5'd7;
`endif

  logic [4:0] addr_q;
  logic [7:0] tmr0_q;
  logic [1:0] inhibit_q;
  logic [7:0] status_q;
  logic [7:0] status_d;
  logic [4:0] fsr_q;
  logic [3:0] porta_q;
  logic [7:0] portb_q;
  logic [7:0] gpr_q [GprBase:31];

  logic [4:0] eff_addr;
  logic       wr_en;
  logic       gpr_we;

  // Address 0 selects indirect access through FSR; a write that still resolves to 0 is dropped.
  assign eff_addr = (addr_q == AddrIndf) ? fsr_q : addr_q;
  assign wr_en    = writeCommand[1] && (eff_addr != AddrIndf);
  assign gpr_we   = wr_en && (eff_addr >= GprBase);

  // Address latch; a write in the same cycle has already used the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (writeCommand[2]) begin
      addr_q <= gprWriteDataIn[4:0];
    end
  end

  // TMR0: a direct load wins over an increment and arms a two-pulse inhibit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr0_q    <= 8'h00;
      inhibit_q <= 2'd0;
    end else if (wr_en && (eff_addr == AddrTmr0)) begin
      tmr0_q    <= gprWriteDataIn;
      inhibit_q <= 2'd2;
    end else if (tmr0Inc) begin
      if (inhibit_q != 2'd0) begin
        inhibit_q <= inhibit_q - 2'd1;
      end else begin
        tmr0_q <= tmr0_q + 8'd1;
      end
    end
  end

  // STATUS next state: TO/PD (bits 4:3) are never written; the register-write path owns
  // bits 7:5 when both write paths hit in the same cycle.
  always_comb begin
    status_d = status_q;
    if (writeCommand[0]) begin
      status_d[7:5] = statusWriteDataIn[7:5];
      status_d[2:0] = statusWriteDataIn[2:0];
    end
    if (wr_en && (eff_addr == AddrStatus)) begin
      status_d[7:5] = gprWriteDataIn[7:5];
      if (!writeCommand[0]) begin
        status_d[2:0] = gprWriteDataIn[2:0];
      end
    end
  end

  // STATUS register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= 8'h18;
    end else begin
      status_q <= status_d;
    end
  end

  // FSR and port latches; FSR stores only its pointer bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsr_q   <= 5'd0;
      porta_q <= 4'h0;
      portb_q <= 8'h00;
    end else if (wr_en) begin
      if (eff_addr == AddrFsr)   fsr_q   <= gprWriteDataIn[4:0];
      if (eff_addr == AddrPortA) porta_q <= gprWriteDataIn[3:0];
      if (eff_addr == AddrPortB) portb_q <= gprWriteDataIn;
    end
  end

`ifdef GPR_FILE_PORTC_EN
  logic [7:0] portc_q;

  // PORTC latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      portc_q <= 8'h00;
    end else if (wr_en && (eff_addr == AddrPortC)) begin
      portc_q <= gprWriteDataIn;
    end
  end

  assign portCOut = portc_q;
`else
  assign portCOut = 8'h00;
`endif

  // General-purpose byte array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = int'(GprBase); i < 32; i++) begin
        gpr_q[i] <= 8'h00;
      end
    end else if (gpr_we) begin
      gpr_q[eff_addr] <= gprWriteDataIn;
    end
  end

  // Read mux on the effective address.
  always_comb begin
    readDataOut = 8'h00;
    case (eff_addr)
      AddrIndf:   readDataOut = 8'h00;
      AddrTmr0:   readDataOut = tmr0_q;
      AddrPcl:    readDataOut = pclIn;
      AddrStatus: readDataOut = status_q;
      AddrFsr:    readDataOut = {3'b111, fsr_q};
      AddrPortA:  readDataOut = {4'b0000, porta_q};
      AddrPortB:  readDataOut = portb_q;
`ifdef GPR_FILE_PORTC_EN
      AddrPortC:  readDataOut = portc_q;
`else
      AddrPortC:  readDataOut = gpr_q[7];
`endif
      default:    readDataOut = gpr_q[eff_addr];
    endcase
  end

  // PCL has no storage here; a write is forwarded to the PC in the same cycle.
  always_comb begin
    pclWriteEn   = wr_en && (eff_addr == AddrPcl);
    pclWriteData = pclWriteEn ? gprWriteDataIn : 8'h00;
  end

  assign statusOut = status_q;
  assign portAOut  = porta_q;
  assign portBOut  = portb_q;

endmodule

// File: doc/gpr_file.md
GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 writeCommand  input  3  [2] latch file address, [1] write data to addressed register, [0] write STATUS.
REQ-004 gprWriteDataIn  input  8  data for writeCommand[2] (bits 4:0 used) and writeCommand[1].
REQ-005 statusWriteDataIn  input  8  STATUS image for writeCommand[0].
REQ-006 tmr0Inc  input  1  one-cycle TMR0 increment request.
REQ-007 pclIn  input  8  current PC low byte, returned on PCL reads.
REQ-008 readDataOut  output  8  combinational content of the effective address.
REQ-009 statusOut  output  8  current STATUS.
REQ-010 pclWriteEn / pclWriteData  output  1 / 8  combinational PCL write strobe and data.
REQ-011 portAOut / portBOut / portCOut  output  4 / 8 / 8  port output latches.

Function
REQ-012 Address map: 0 INDF, 1 TMR0, 2 PCL, 3 STATUS, 4 FSR, 5 PORTA, 6 PORTB, 7 PORTC, 8-31 GPR (24 bytes).
REQ-013 writeCommand[2]: addrLatch <= gprWriteDataIn[4:0]; readDataOut reflects the new address from the next cycle.
REQ-014 Effective address = addrLatch, or FSR[4:0] when addrLatch==0 (indirect).
REQ-015 Indirect with FSR[4:0]==0: read returns 8'h00, write is a no-op.
REQ-016 writeCommand[1]: write gprWriteDataIn to the effective register using addrLatch before any same-cycle [2] update.
REQ-017 FSR: bits 4:0 writable, bits 7:5 always read 1.
REQ-018 PORTA: only bits 3:0 stored; reads of address 5 return {4'b0000, portA}.
REQ-019 PCL: no storage; read returns pclIn; write asserts pclWriteEn with pclWriteData=gprWriteDataIn in the same cycle; pclWriteData = 0 otherwise.
REQ-020 STATUS bits 4:3 (TO, PD) read-only to all writes; bits 7:5 and 2:0 writable.
REQ-021 writeCommand[0] alone: STATUS[7:5,2:0] <= statusWriteDataIn[7:5,2:0].
REQ-022 [0] and [1] with effective address 3 in the same cycle: STATUS[7:5] <= gprWriteDataIn[7:5]; STATUS[2:0] <= statusWriteDataIn[2:0].
REQ-023 TMR0 increments by 1 mod 256 (8'hFF wraps to 8'h00) on each tmr0Inc when the inhibit count is 0.
REQ-024 A TMR0 write loads the data, ignores any same-cycle tmr0Inc, and sets the inhibit count to 2.
REQ-025 Each tmr0Inc with inhibit count >0 decrements the count instead of incrementing TMR0.
REQ-026 Reads of unimplemented addresses return 8'h00.

Reset
REQ-027 rst asynchronously sets:
- addrLatch = 0, TMR0 = 8'h00, inhibit count = 0.
- STATUS = 8'h18, FSR = 8'hE0.
- all ports = 0, all GPRs = 8'h00.
REQ-028 Reset asserted mid-write discards the write; the first write takes effect on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro GPR_FILE_PORTC_EN.
- Defined: address 7 is PORTC; portCOut is driven from the PORTC latch.
- Undefined: address 7 is an additional GPR (25 GPRs total) and portCOut is tied to 8'h00.

Verification
REQ-030 Latch address 8, write 8'h5A, latch 8 again -> readDataOut = 8'h5A.
REQ-031 Write FSR = 8'h09, latch 0, write 8'hC3 -> GPR 9 = 8'hC3; readDataOut = 8'hC3; FSR reads 8'hE9.
REQ-032 Latch 3, assert writeCommand = 3'b011 with data 8'hFF and status 8'h05 -> statusOut = 8'hFD (TO/PD retained at 1, 1).
REQ-033 Write TMR0 = 8'hFE, then 4 tmr0Inc pulses -> values FE, FE, FF, 00.
REQ-034 Latch 2, write 8'h33 -> pclWriteEn high for 1 cycle with pclWriteData = 8'h33; read of address 2 returns pclIn.
REQ-035 Latch 7, write 8'hA5 -> portCOut = 8'hA5 with GPR_FILE_PORTC_EN defined; portCOut = 8'h00 and readback = 8'hA5 without it.
